// File: rtl/image_resize_line_ctrl.sv
// Ping-pong line-buffer scheduler for the resize RAM: writes lines into two banks
// and replays, streams-and-frees or drops them on command from the vertical sequencer.
module image_resize_line_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-2:0] line_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  rd_start,
    input  logic                  rd_free,
    input  logic                  rd_drop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  rd_busy,
    output logic [1:0]            lines_avail,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [1:0]            rd_state_dbg
);
    localparam int LW = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_DRAIN} rd_state_t;

    // Handshakes: a pixel moves on in_valid & in_ready and on out_valid & out_ready;
    // valid never waits for ready, and data/last hold while valid is high and ready low.

    bank_state_t     bank_state [2];
    logic [LW-1:0]   bank_len   [2];
    logic            run_q;
    logic            wr_bank;
    logic [LW-1:0]   wcnt;
    logic            rd_bank;
    logic [LW-1:0]   rcnt;
    rd_state_t       rd_state, rd_state_nxt;
    logic            free_q;
    logic            inflight, inflight_last;
    logic [DATA_WIDTH:0] fifo_mem [2];
    logic            fifo_wptr, fifo_rptr;
    logic [1:0]      fifo_count;

    logic            wr_accept, wr_last;
    logic [LW-1:0]   wr_len, rd_last_idx, rd_idx;
    logic            avail, pop, rd_issue, drop_bank, free_bank, rd_release;
    logic [1:0]      occ, occ_after;

    assign in_ready    = run_q && (bank_state[wr_bank] != BANK_FULL);
    assign wr_accept   = in_valid && in_ready;
    // A bank's length is taken from line_len only while it is still empty.
    assign wr_len      = (bank_state[wr_bank] == BANK_EMPTY) ? line_len : bank_len[wr_bank];
    assign wr_last     = (wcnt == wr_len - LW'(1));
    assign ram_wr_en   = wr_accept;
    assign ram_wr_addr = {wr_bank, wcnt};
    assign ram_wr_data = wr_accept ? in_data : '0;

    assign lines_avail = {1'b0, bank_state[0] == BANK_FULL} + {1'b0, bank_state[1] == BANK_FULL};
    assign avail       = (lines_avail != 2'd0);
    assign rd_last_idx = bank_len[rd_bank] - LW'(1);

    assign out_valid   = (fifo_count != 2'd0);
    assign out_data    = fifo_mem[fifo_rptr][DATA_WIDTH-1:0];
    assign out_last    = out_valid && fifo_mem[fifo_rptr][DATA_WIDTH];
    assign pop         = out_valid && out_ready;
    assign occ         = fifo_count + {1'b0, inflight};
    assign occ_after   = occ - {1'b0, pop};

    assign rd_busy      = (rd_state != RD_IDLE);
    assign rd_state_dbg = rd_state;
    assign ram_rd_addr  = {rd_bank, rd_idx};
    assign rd_release   = drop_bank || free_bank;

    always_comb begin
        rd_state_nxt = rd_state;
        rd_issue     = 1'b0;
        rd_idx       = rcnt;
        drop_bank    = 1'b0;
        free_bank    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                rd_idx = '0;
                if (rd_drop && avail) begin
                    drop_bank = 1'b1;
                end else if (rd_start && avail) begin
                    // Pixel 0 is read in the accepting cycle so it reaches out_valid two cycles on.
                    rd_issue     = 1'b1;
                    rd_state_nxt = (rd_last_idx == '0) ? RD_DRAIN : RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (occ_after < 2'd2) begin
                    rd_issue = 1'b1;
                    if (rcnt == rd_last_idx) rd_state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
                    rd_state_nxt = RD_IDLE;
                    free_bank    = free_q;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rcnt     <= '0;
            free_q   <= 1'b0;
            rd_bank  <= 1'b0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            rd_state      <= rd_state_nxt;
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (rd_idx == rd_last_idx);
            if (rd_issue) rcnt <= rd_idx + LW'(1);
            if (rd_state == RD_IDLE && rd_issue) free_q <= rd_free;
            if (rd_release) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            wr_bank <= 1'b0;
            wcnt    <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_EMPTY;
                bank_len[b]   <= '0;
            end
        end else begin
            run_q <= 1'b1;
            if (wr_accept) begin
                wcnt <= wr_last ? '0 : wcnt + LW'(1);
                if (wr_last) wr_bank <= ~wr_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (wr_accept && wr_bank == 1'(b)) begin
                    if (bank_state[b] == BANK_EMPTY) bank_len[b] <= line_len;
                    bank_state[b] <= wr_last ? BANK_FULL : BANK_FILLING;
                end else if (rd_release && rd_bank == 1'(b)) begin
                    bank_state[b] <= BANK_EMPTY;
                end
            end
        end
    end

    // Two-entry output FIFO fed by the registered RAM read one cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wptr   <= 1'b0;
            fifo_rptr   <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (inflight) begin
                fifo_mem[fifo_wptr] <= {inflight_last, ram_rd_data};
                fifo_wptr           <= ~fifo_wptr;
            end
            if (pop) fifo_rptr <= ~fifo_rptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_image_resize_line_ctrl.sv
// Bench for image_resize_line_ctrl: directed line writes/reads against a RAM model,
// with a queue scoreboard checked by an independent output monitor.
module tb_image_resize_line_ctrl;
  localparam int AW = 11;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-2:0] line_len = '0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready;
  logic rd_start = 1'b0;
  logic rd_free = 1'b0;
  logic rd_drop = 1'b0;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic out_ready = 1'b1;
  logic out_last;
  logic rd_busy;
  logic [1:0] lines_avail;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic ram_wr_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [1:0] rd_state_dbg;

  int total = 0;
  int bad = 0;
  int n_pop = 0;
  int n_last = 0;
  logic [DW:0] exp_q[$];
  logic rand_mode = 1'b0;
  logic exp_wbank = 1'b0;
  logic exp_rbank = 1'b0;
  logic [DW-1:0] ram_mem [2**AW];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  image_resize_line_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .line_len(line_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_start(rd_start), .rd_free(rd_free), .rd_drop(rd_drop),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .rd_busy(rd_busy), .lines_avail(lines_avail),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .rd_state_dbg(rd_state_dbg)
  );

  // simple dual-port RAM with registered read
  always @(posedge clk) if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
  always @(posedge clk or posedge rst) begin
    if (rst) ram_rd_data <= '0;
    else     ram_rd_data <= ram_mem[ram_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_pop++;
      if (out_last) n_last++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got=%0h want=none", {out_last, out_data});
      end else begin
        check("out_pix", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic write_line(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = base + DW'(i);
      @(negedge clk);
      check("wr_en", 32'(ram_wr_en), 32'd1);
      check("wr_addr", 32'(ram_wr_addr), 32'({exp_wbank, (AW-1)'(i)}));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_wbank = ~exp_wbank;
  endtask

  task automatic read_line(input logic free, input logic [DW-1:0] base, input int len, input int npush);
    for (int i = 0; i < npush; i++) exp_q.push_back({i == len - 1, base + DW'(i)});
    @(posedge clk); #1;
    rd_start = 1'b1;
    rd_free = free;
    @(negedge clk);
    check("rd_addr_first", 32'(ram_rd_addr), 32'({exp_rbank, (AW-1)'(0)}));
    @(posedge clk); #1;
    rd_start = 1'b0;
    rd_free = 1'b0;
    @(negedge clk);
    check("latency_c1_valid", 32'(out_valid), 32'd0);
    check("latency_c1_busy", 32'(rd_busy), 32'd1);
    @(negedge clk);
    check("latency_c2_valid", 32'(out_valid), 32'd1);
    if (free) exp_rbank = ~exp_rbank;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while ((rd_busy || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'({rd_busy, exp_q.size() != 0}), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_lines_avail", 32'(lines_avail), 32'd0);
    check("rst_rd_busy", 32'(rd_busy), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready_0", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_in_ready_1", 32'(in_ready), 32'd1);

    // one line of 4 into bank 0, stream and free
    line_len = 10'd4;
    write_line(4, 24'h000001);
    @(negedge clk);
    check("t1_lines_avail", 32'(lines_avail), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    read_line(1'b1, 24'h000001, 4, 4);
    wait_idle(50);
    check("t2_lines_avail", 32'(lines_avail), 32'd0);

    // replay twice, then release
    write_line(4, 24'h000005);
    read_line(1'b0, 24'h000005, 4, 4);
    wait_idle(50);
    check("t3_avail_after_replay1", 32'(lines_avail), 32'd1);
    read_line(1'b0, 24'h000005, 4, 4);
    wait_idle(50);
    check("t3_avail_after_replay2", 32'(lines_avail), 32'd1);
    read_line(1'b1, 24'h000005, 4, 4);
    wait_idle(50);
    check("t3_avail_after_free", 32'(lines_avail), 32'd0);

    // rd_start with nothing buffered is ignored
    @(posedge clk); #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    check("t4_empty_start_busy", 32'(rd_busy), 32'd0);
    check("t4_empty_start_valid", 32'(out_valid), 32'd0);

    // both banks full, writer stalls, drop beats a simultaneous start
    write_line(4, 24'h000010);
    write_line(4, 24'h000020);
    @(negedge clk);
    check("t4_avail_two", 32'(lines_avail), 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 24'hdead00;
    @(negedge clk);
    check("t4_stall_ready", 32'(in_ready), 32'd0);
    check("t4_stall_wr_en", 32'(ram_wr_en), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd_drop = 1'b1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_drop = 1'b0;
    rd_start = 1'b0;
    exp_rbank = ~exp_rbank;
    @(negedge clk);
    check("t4_drop_prio_busy", 32'(rd_busy), 32'd0);
    check("t4_drop_avail", 32'(lines_avail), 32'd1);
    check("t4_drop_in_ready", 32'(in_ready), 32'd1);
    read_line(1'b1, 24'h000020, 4, 4);
    wait_idle(50);
    check("t4_avail_end", 32'(lines_avail), 32'd0);

    // 1024-pixel line with random downstream stalls
    line_len = 10'd0;
    write_line(1024, 24'h400000);
    @(negedge clk);
    check("t5_avail", 32'(lines_avail), 32'd1);
    n_pop = 0;
    n_last = 0;
    rand_mode = 1'b1;
    read_line(1'b1, 24'h400000, 1024, 1024);
    wait_idle(5000);
    rand_mode = 1'b0;
    check("t5_pop_count", 32'(n_pop), 32'd1024);
    check("t5_last_count", 32'(n_last), 32'd1);
    check("t5_avail_end", 32'(lines_avail), 32'd0);

    // reset in the middle of a stream
    line_len = 10'd4;
    write_line(4, 24'h000a00);
    read_line(1'b1, 24'h000a00, 4, 2);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_wbank = 1'b0;
    exp_rbank = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(rd_busy), 32'd0);
    check("t6_rst_avail", 32'(lines_avail), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    check("t6_rst_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rel_valid", 32'(out_valid), 32'd0);
    check("t6_rel_in_ready", 32'(in_ready), 32'd1);
    write_line(4, 24'h000b00);
    read_line(1'b1, 24'h000b00, 4, 4);
    wait_idle(50);
    check("t6_avail_end", 32'(lines_avail), 32'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_resize_line_ctrl.md
Name: image_resize_line_ctrl

Overview:
- Ping-pong line-buffer scheduler in front of the 2048x24 simple dual-port resize RAM; both RAM clocks are tied to clk.
- Splits the RAM into two banks selected by the address MSB.
- Writes incoming pixel lines into whichever bank is free.
- Replays or releases each buffered line on command from the vertical resize sequencer, which enables line duplication (upscale) and line skipping (downscale).

Parameters:
- ADDR_WIDTH, 11, RAM address width; bank size is 2^(ADDR_WIDTH-1) = 1024 pixels.
- DATA_WIDTH, 24, pixel width (RGB888).

Ports:
- clk  in  1  system clock; drives the RAM wr_clk and rd_clk.
- rst  in  1  reset, asynchronous, active-high; also drives the RAM wr_rst and rd_rst.
- line_len  in  ADDR_WIDTH-1  pixels per line, 1..1023; 0 means 1024.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_WIDTH  input pixel.
- in_ready  out  1  controller accepts the pixel this cycle.
- rd_start  in  1  pulse: stream the oldest full line.
- rd_free  in  1  sampled with rd_start: 1 = release the bank after streaming.
- rd_drop  in  1  pulse: release the oldest full line without streaming it.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_WIDTH  output pixel.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the last pixel of the line; qualified by out_valid.
- rd_busy  out  1  a streaming pass is in progress.
- lines_avail  out  2  number of FULL banks, 0..2.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_en  out  1  to RAM wr_en.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data; registered read, valid 1 cycle after ram_rd_addr.

Behaviour:
- Reset values: every output is 0, in_ready included.
  - Both banks EMPTY; wr_bank = rd_bank = 0; output FIFO empty.
  - in_ready goes to 1 on the first clk after rst deasserts.
- Each bank has state EMPTY, FILLING or FULL, plus a stored length len[b].
- Write side:
  - in_ready = 1 when bank wr_bank is EMPTY or FILLING.
  - On in_valid & in_ready: ram_wr_en=1, ram_wr_addr={wr_bank, wcnt}, ram_wr_data=in_data. These are combinational outputs; the RAM registers them.
  - The first pixel of a bank latches line_len into len[wr_bank], and the bank goes to FILLING.
  - wcnt wraps at len-1. On the last pixel the bank goes FULL, wr_bank toggles and wcnt clears.
- Read side has states IDLE, STREAM, DRAIN.
  - IDLE: rd_start with lines_avail>0 latches rd_free and enters STREAM with rcnt=0. rd_start with lines_avail=0 or while rd_busy is ignored.
  - STREAM: one read is issued per cycle while fifo_count + inflight < 2. ram_rd_addr={rd_bank, rcnt}, and the data is pushed into a 2-entry output FIFO one cycle later.
  - After read len[rd_bank]-1 is issued, the state goes to DRAIN.
  - DRAIN: when the FIFO empties, the state returns to IDLE.
  - If rd_free was latched, bank rd_bank goes EMPTY and rd_bank toggles in that same cycle. Otherwise the bank stays FULL and the next rd_start replays it.
- rd_busy = 1 in STREAM and DRAIN.
- out_valid = FIFO not empty; out_data = FIFO head.
- out_last = 1 when the head entry is pixel len-1.
- rd_drop in IDLE with lines_avail>0 sets bank rd_bank EMPTY and toggles rd_bank. Otherwise it is ignored. rd_drop has priority over a simultaneous rd_start.
- The write side may fill bank wr_bank while the read side streams the other bank.
- Writing to, and freeing, the same bank in the same cycle cannot occur, because the writer requires EMPTY/FILLING and the reader requires FULL.
- A write completing and a free in the same cycle update lines_avail by +1 and -1, giving net 0.
- Throughput: 1 pixel/clk on each side with no backpressure. The first out_valid appears 2 cycles after the rd_start cycle.
- rst asserted mid-line or mid-stream clears all state immediately. FIFO contents and partial lines are discarded, and no out_valid is generated from pre-reset reads.
- line_len changes affect only banks whose fill starts afterwards.

Test Plan:
- line_len=4; write 4 pixels 0x000001..0x000004 → ram_wr_addr 0..3, lines_avail=1, wr_bank=1.
- rd_start with rd_free=1, out_ready=1 → out_valid exactly 2 cycles later; data 1,2,3,4; out_last on pixel 4; lines_avail=0; rd_bank=1.
- rd_start twice with rd_free=0, then once with rd_free=1 on the same line → the same 4 pixels appear three times, then the bank is released.
- Fill 2 lines (8 pixels) with no reads → in_ready=0 at the 9th pixel. rd_drop → in_ready=1, and the next output is the second line (addresses 1024..1027).
- line_len=0 (1024 px); toggle out_ready randomly while streaming → no pixel lost or duplicated, FIFO never overflows, and exactly 1024 outputs end with out_last.
- Assert rst during STREAM at pixel 2 → next cycle out_valid=0, rd_busy=0, lines_avail=0, in_ready=0; after release in_ready=1 and a fresh line writes from address 0.
